// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with maskable level interrupt
module timer_dev #(
    parameter int BASE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BASE_W-1:0] Addr,
    input  logic              We,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic              IRQ
);

    localparam logic [BASE_W-1:0] A_CTRL   = BASE_W'(0);
    localparam logic [BASE_W-1:0] A_PRESET = BASE_W'(1);
    localparam logic [BASE_W-1:0] A_COUNT  = BASE_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // {IM, MODE[1:0], EN}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;

    logic en;
    logic auto_reload;
    logic wr_ctrl;
    logic wr_preset;
    logic pend_set;
    logic pend_clr;

    assign en          = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign wr_ctrl     = We && (Addr == A_CTRL);
    assign wr_preset   = We && (Addr == A_PRESET);

    // Register state; reset wins over every other input on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    // Next-state logic: FSM first, then CPU writes so they override hardware updates of CTRL
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_set = 1'b0;
        pend_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // PRESET of 0 lands here too, so it behaves like 1
                    count_d  = 32'd0;
                    pend_set = 1'b1;
                    state_d  = S_INT;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    pend_clr = 1'b1;
                    state_d  = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wr_ctrl) begin
            ctrl_d   = Din[3:0];
            pend_clr = 1'b1;
        end
        if (wr_preset) begin
            preset_d = Din;
            pend_clr = 1'b1;
        end

        // A set on the same edge as a clear leaves the interrupt pending
        if (pend_set) begin
            pend_d = 1'b1;
        end else if (pend_clr) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Read mux straight from the registers, no latency
    always_comb begin
        case (Addr)
            A_CTRL:   Dout = {28'd0, ctrl_q};
            A_PRESET: Dout = preset_q;
            A_COUNT:  Dout = count_q;
            default:  Dout = 32'd0;
        endcase
    end

    assign IRQ = pend_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed-vector bench for timer_dev
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_vec;
    int n_err;

    timer_dev #(.BASE_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .We   (We),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        We   = 1'b1;
        Addr = a;
        Din  = d;
        @(posedge clk);
        #1;
        We   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check_val(tag, Dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check_val(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        We    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;

        // reset state
        do_reset();
        do_reset();
        rd("rst_ctrl", 2'd0, 32'd0);
        rd("rst_preset", 2'd1, 32'd0);
        rd("rst_count", 2'd2, 32'd0);
        rd("rst_addr3", 2'd3, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // one-shot, PRESET=5, CTRL=0x9 at edge k
        wr(2'd1, 32'd5);
        rd("os_preset", 2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            rd($sformatf("os_count_%0d", i), 2'd2, 32'(5 - i));
        end
        chk_irq("os_irq_k6", 1'b0);
        tick();
        chk_irq("os_irq_k7", 1'b1);
        rd("os_count_k7", 2'd2, 32'd0);
        tick();
        chk_irq("os_irq_k8", 1'b1);
        rd("os_ctrl_autoclr", 2'd0, 32'h8);
        tick();
        chk_irq("os_irq_sticky", 1'b1);
        wr(2'd0, 32'h8);
        chk_irq("os_irq_cleared", 1'b0);

        // auto-reload, PRESET=3, CTRL=0xB at edge k
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        Addr = 2'd2;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk_irq($sformatf("ar_irq_c%0d", c), (c == 5) || (c == 10) || (c == 15));
            if (c == 2 || c == 7 || c == 12) begin
                rd($sformatf("ar_reload_c%0d", c), 2'd2, 32'd3);
            end
        end
        wr(2'd0, 32'h0);
        tick();
        tick();

        // IM=0, PRESET=2: expiry without IRQ, late IM write clears pend
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd("im0_count2", 2'd2, 32'd2);
        tick();
        rd("im0_count1", 2'd2, 32'd1);
        tick();
        chk_irq("im0_irq_int", 1'b0);
        rd("im0_count_int", 2'd2, 32'd0);
        tick();
        rd("im0_ctrl_enclr", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("im0_late_im", 1'b0);

        // IM written on the very edge pend is set: set wins
        wr(2'd0, 32'h1);
        tick();
        tick();
        tick();
        wr(2'd0, 32'h8);
        chk_irq("setwins_irq", 1'b1);
        tick();
        chk_irq("setwins_irq_hold", 1'b1);
        rd("setwins_ctrl", 2'd0, 32'h8);
        wr(2'd0, 32'h0);
        chk_irq("setwins_clr", 1'b0);

        // PRESET change mid-count, then disable freezes COUNT
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 6; i++) tick();
        rd("mid_count6", 2'd2, 32'd6);
        wr(2'd1, 32'd2);
        rd("mid_count5", 2'd2, 32'd5);
        tick();
        rd("mid_count4", 2'd2, 32'd4);
        wr(2'd0, 32'h0);
        rd("mid_count3", 2'd2, 32'd3);
        tick();
        tick();
        rd("mid_frozen", 2'd2, 32'd3);
        wr(2'd0, 32'h1);
        rd("re_idle", 2'd2, 32'd3);
        tick();
        rd("re_load", 2'd2, 32'd3);
        tick();
        rd("re_reloaded", 2'd2, 32'd2);

        // writes to COUNT and Addr 3 ignored
        wr(2'd2, 32'hFFFF_FFFF);
        rd("ign_count", 2'd2, 32'd1);
        wr(2'd3, 32'h0000_1234);
        rd("ign_addr3", 2'd3, 32'd0);
        rd("ign_ctrl", 2'd0, 32'h1);
        rd("ign_preset", 2'd1, 32'd2);
        chk_irq("ign_irq_masked", 1'b0);
        tick();

        // reset while IRQ is high in auto-reload
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int i = 0; i < 5; i++) tick();
        chk_irq("pre_rst_irq", 1'b1);
        do_reset();
        chk_irq("mr_irq", 1'b0);
        rd("mr_ctrl", 2'd0, 32'd0);
        rd("mr_preset", 2'd1, 32'd0);
        rd("mr_count", 2'd2, 32'd0);

        // reset mid-count in CNT
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        tick();
        tick();
        tick();
        rd("cnt_pre_rst", 2'd2, 32'd3);
        do_reset();
        rd("cnt_rst_count", 2'd2, 32'd0);
        rd("cnt_rst_ctrl", 2'd0, 32'd0);
        tick();
        tick();
        tick();
        rd("cnt_rst_idle", 2'd2, 32'd0);
        chk_irq("cnt_rst_irq", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
